// File: rtl/xor_parity_checker.sv
// xor_parity_checker
//   Collects a serial stream of XOR result bits into frames of FRAME_LEN bits.
//   The last bit of each frame is its parity bit. Each finished frame produces
//   one pass/fail result on the output handshake. The block also keeps
//   saturating counters of finished and failed frames.
//
//   Build option: define PARITY_ODD_EN to check odd parity. A frame then passes
//   when the XOR of all its bits is 1. With the macro undefined, the block
//   checks even parity and a frame passes when that XOR is 0. Ports and timing
//   are the same in both builds.
//
//   Handshake semantics, for both the input and output sides: a transfer
//   happens on a rising clk edge where valid && ready. Once the producer raises
//   valid, it keeps valid and data stable until that transfer. ready never
//   depends on valid in the same cycle, because both in_ready and out_valid
//   come straight from registers.
module xor_parity_checker #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ok,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             dbg_state_o
);

  // A frame has to hold at least one data bit plus its parity bit.
  if (FRAME_LEN < 2 || FRAME_LEN > 256) begin : g_bad_frame_len
    $error("xor_parity_checker: FRAME_LEN must be within 2..256");
  end

  localparam int unsigned     IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

`ifdef PARITY_ODD_EN
  localparam logic EXP_PAR = 1'b1;
`else
  localparam logic EXP_PAR = 1'b0;
`endif

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_REPORT = 1'b1
  } state_e;

  state_e           state_q;
  logic             acc_q;
  logic [IDX_W-1:0] idx_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_ok_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic             in_xfer;
  logic             out_xfer;
  logic             last_bit;
  logic             frame_ok_d;
  logic [CNT_W-1:0] frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_d;

  // Decode the handshakes, build the closing-frame verdict and the saturating counter increments.
  always_comb begin
    in_xfer     = in_valid && in_ready_q;
    out_xfer    = out_valid_q && out_ready;
    last_bit    = (idx_q == LAST_IDX);
    frame_ok_d  = ((acc_q ^ in_bit) == EXP_PAR);
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (frame_cnt_q != {CNT_W{1'b1}}) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
    if (!frame_ok_d && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Frame FSM: accumulate bits in ACCUM, then hold the registered verdict in REPORT until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_ok_q    <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_ACCUM: begin
          if (in_xfer) begin
            if (last_bit) begin
              // The parity bit closes the frame: latch the verdict and stop
              // taking input until the result has been consumed.
              out_ok_q    <= frame_ok_d;
              frame_cnt_q <= frame_cnt_d;
              err_cnt_q   <= err_cnt_d;
              acc_q       <= 1'b0;
              idx_q       <= '0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= ST_REPORT;
            end else begin
              acc_q <= acc_q ^ in_bit;
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_REPORT: begin
          // in_ready rises only after the cycle of the output transfer. This
          // leaves one bubble cycle per frame, and it keeps in_ready a pure
          // register output.
          if (out_xfer) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_ACCUM;
          end
        end
        default: begin
          state_q     <= ST_ACCUM;
          acc_q       <= 1'b0;
          idx_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_ok      = out_ok_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_xor_parity_checker.sv
// tb_xor_parity_checker
//   Directed, table-driven bench for xor_parity_checker with FRAME_LEN=8.
//   It drives two instances from the same stimulus: one with 8-bit counters
//   and one with 2-bit counters, so that counter saturation is visible.
//   Expected results follow PARITY_ODD_EN in the same way the design does.
module tb_xor_parity_checker;

  localparam int FL = 8;

`ifdef PARITY_ODD_EN
  localparam logic EXP_PAR = 1'b1;
`else
  localparam logic EXP_PAR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic in_valid  = 1'b0;
  logic in_bit    = 1'b0;
  logic out_ready = 1'b1;

  logic       in_ready, out_valid, out_ok, dbg_state;
  logic [7:0] frame_cnt, err_cnt;
  logic       in_ready2, out_valid2, out_ok2, dbg_state2;
  logic [1:0] frame_cnt2, err_cnt2;

  always #5 clk = ~clk;

  xor_parity_checker #(.FRAME_LEN(FL), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .out_valid(out_valid), .out_ready(out_ready),
    .out_ok(out_ok), .frame_cnt(frame_cnt), .err_cnt(err_cnt),
    .dbg_state_o(dbg_state)
  );

  xor_parity_checker #(.FRAME_LEN(FL), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_bit(in_bit), .out_valid(out_valid2), .out_ready(out_ready),
    .out_ok(out_ok2), .frame_cnt(frame_cnt2), .err_cnt(err_cnt2),
    .dbg_state_o(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  int exp_fc, exp_ec, exp_fc2, exp_ec2;

  typedef struct {
    logic [7:0] bits;     // bits[7] is sent first
    logic       exp_par;  // hand-computed XOR of all eight bits
    string      name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_counters(input string name);
    chk({name, ".frame_cnt"},  frame_cnt,  exp_fc);
    chk({name, ".err_cnt"},    err_cnt,    exp_ec);
    chk({name, ".frame_cnt2"}, frame_cnt2, exp_fc2);
    chk({name, ".err_cnt2"},   err_cnt2,   exp_ec2);
  endtask

  task automatic model_reset();
    exp_fc = 0; exp_ec = 0; exp_fc2 = 0; exp_ec2 = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // Present one bit and hold it until the block accepts it.
  task automatic send_bit(input logic b, input int gap);
    int budget;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = b;
    budget   = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) chk("send_bit.timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  // Send a whole frame and record the expected verdict.
  task automatic send_frame(input logic [7:0] bits, input logic exp_par,
                            input int max_gap, input string name);
    logic ok;
    ok = (exp_par == EXP_PAR);
    exp_q.push_back(ok);
    exp_fc  = (exp_fc  < 255) ? exp_fc  + 1 : exp_fc;
    exp_fc2 = (exp_fc2 < 3)   ? exp_fc2 + 1 : exp_fc2;
    if (!ok) begin
      exp_ec  = (exp_ec  < 255) ? exp_ec  + 1 : exp_ec;
      exp_ec2 = (exp_ec2 < 3)   ? exp_ec2 + 1 : exp_ec2;
    end
    for (int i = FL - 1; i >= 0; i--) begin
      send_bit(bits[i], $urandom_range(0, max_gap));
    end
    // This is #1 after the edge that transferred the parity bit.
    chk({name, ".latency_out_valid"}, out_valid, 1);
    chk({name, ".in_ready_report"},   in_ready,  0);
    chk({name, ".dbg_state"},         dbg_state, 1);
  endtask

  // Consume one result and compare it with the scoreboard.
  task automatic take_result(input string name);
    int budget;
    logic [0:0] exp;
    budget = 0;
    @(negedge clk);
    while (!out_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!out_valid) chk({name, ".result_timeout"}, 0, 1);
    if (exp_q.size() == 0) begin
      chk({name, ".unexpected_result"}, 1, 0);
      exp = 1'b0;
    end else begin
      exp = exp_q.pop_front();
    end
    chk({name, ".out_ok"},     out_ok,     exp);
    chk({name, ".out_ok2"},    out_ok2,    exp);
    chk({name, ".out_valid2"}, out_valid2, 1);
    chk_counters(name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, ".out_valid_after"}, out_valid, 0);
    chk({name, ".in_ready_after"},  in_ready,  1);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[6];
  logic [7:0] bad_bits;
  logic       stall_exp;

  initial begin
    vecs[0] = '{8'b1011_0001, 1'b0, "spec_1011_0001"};
    vecs[1] = '{8'b1000_0000, 1'b1, "single_one"};
    vecs[2] = '{8'b0110_0110, 1'b0, "ab_sweep"};
    vecs[3] = '{8'b1111_1111, 1'b0, "all_ones"};
    vecs[4] = '{8'b1111_1110, 1'b1, "seven_ones"};
    vecs[5] = '{8'b0000_0001, 1'b1, "parity_bit_only"};

    // Reset state and idle.
    do_reset();
    chk("reset.in_ready",  in_ready,  1);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.out_ok",    out_ok,    0);
    chk("reset.dbg_state", dbg_state, 0);
    chk_counters("reset");

    // Table-driven frames, back to back with out_ready held high.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].bits, vecs[i].exp_par, 0, vecs[i].name);
      take_result(vecs[i].name);
    end

    // a/b sweep stream again, this time with in_valid idling randomly between bits.
    for (int r = 0; r < 3; r++) begin
      send_frame(8'b0110_0110, 1'b0, 3, "ab_sweep_gappy");
      take_result("ab_sweep_gappy");
    end

    // Hold out_ready low for 5 cycles. The result must hold, and stray input must be ignored.
    out_ready = 1'b0;
    send_frame(8'b1011_0001, 1'b0, 0, "stall");
    stall_exp = (1'b0 == EXP_PAR);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = 1'b1;
      chk("stall.out_valid", out_valid, 1);
      chk("stall.out_ok",    out_ok,    stall_exp);
      chk("stall.in_ready",  in_ready,  0);
      chk("stall.frame_cnt", frame_cnt, exp_fc);
    end
    in_valid = 1'b0;
    take_result("stall");
    send_frame(8'b1000_0000, 1'b1, 0, "after_stall");
    take_result("after_stall");

    // Reset mid-frame: outputs return at once and the partial frame is discarded.
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid.in_ready",  in_ready,  1);
    chk("rst_mid.out_valid", out_valid, 0);
    chk("rst_mid.out_ok",    out_ok,    0);
    chk_counters("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'b1011_0001, 1'b0, 0, "post_rst_mid");
    take_result("post_rst_mid");

    // Reset while a result is waiting in REPORT.
    out_ready = 1'b0;
    send_frame(8'b1000_0000, 1'b1, 0, "rst_report");
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_report.in_ready",  in_ready,  1);
    chk("rst_report.out_valid", out_valid, 0);
    chk("rst_report.dbg_state", dbg_state, 0);
    chk_counters("rst_report");
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Saturation: 5 failing frames. The 2-bit counters stop at 3 and the 8-bit counters reach 5.
    bad_bits = {7'b0, ~EXP_PAR};
    for (int f = 0; f < 5; f++) begin
      send_frame(bad_bits, ~EXP_PAR, 0, "sat_bad");
      take_result("sat_bad");
    end
    chk("sat.frame_cnt2_final", frame_cnt2, 3);
    chk("sat.err_cnt2_final",   err_cnt2,   3);
    chk("sat.frame_cnt_final",  frame_cnt,  5);
    // At saturation, a passing frame must still report ok.
    send_frame(8'b1011_0001, 1'b0, 0, "sat_good");
    take_result("sat_good");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
